// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes: single-cycle logic/arith ops, optional shift-add MUL.
// Optional feature macro: ALU_MC_MUL_EN builds the MUL state, bit counter and product register.
module alu_mc #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             zero,
   output logic             set,
   output logic             overflow,
   output logic             illegal
);

   // state | meaning
   // IDLE  | waiting for an operation, in_ready=1
   // MUL   | shift-add multiply, one bit of b per cycle (ALU_MC_MUL_EN only)
   // DONE  | result and flags presented, waiting for out_ready

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_MUL = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_NOR = 3'b101;
   localparam logic [2:0] OP_SUB = 3'b110;
   localparam logic [2:0] OP_SLT = 3'b111;

`ifdef ALU_MC_MUL_EN
   typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DONE = 2'd2} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`endif

   state_t state, state_next;

   logic [WIDTH:0]   add_ext, sub_ext;
   logic             add_ovf, sub_ovf, slt;
   logic [WIDTH-1:0] alu_res;
   logic             alu_cout, alu_ovf, alu_ill;

   always_comb begin
      add_ext  = {1'b0, a} + {1'b0, b};
      sub_ext  = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
      add_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (add_ext[WIDTH-1] != a[WIDTH-1]);
      sub_ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (sub_ext[WIDTH-1] != a[WIDTH-1]);
      slt      = sub_ext[WIDTH-1] ^ sub_ovf;
      alu_res  = '0;
      alu_cout = 1'b0;
      alu_ovf  = 1'b0;
      alu_ill  = 1'b0;
      case (op)
         OP_AND: alu_res = a & b;
         OP_OR:  alu_res = a | b;
         OP_XOR: alu_res = a ^ b;
         OP_NOR: alu_res = ~(a | b);
         OP_ADD: begin
            alu_res  = add_ext[WIDTH-1:0];
            alu_cout = add_ext[WIDTH];
            alu_ovf  = add_ovf;
         end
         OP_SUB: begin
            alu_res  = sub_ext[WIDTH-1:0];
            alu_cout = sub_ext[WIDTH];
            alu_ovf  = sub_ovf;
         end
         OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, slt};
         default: begin
`ifndef ALU_MC_MUL_EN
            alu_ill = 1'b1;
`endif
         end
      endcase
   end

`ifdef ALU_MC_MUL_EN
   localparam int CW = $clog2(WIDTH);

   logic [WIDTH-1:0]   a_r, b_r;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] prod, prod_next;
   logic               cnt_last;

   always_comb begin
      cnt_last  = (cnt == CW'(WIDTH - 1));
      prod_next = prod;
      if (b_r[cnt])
         prod_next = prod + ({{WIDTH{1'b0}}, a_r} << cnt);
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_next = DONE;
`ifdef ALU_MC_MUL_EN
               if (op == OP_MUL)
                  state_next = MUL;
`endif
            end
         end
`ifdef ALU_MC_MUL_EN
         MUL: begin
            if (cnt_last)
               state_next = DONE;
         end
`endif
         DONE: begin
            out_valid = 1'b1;
            if (out_ready)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Outputs are registers written only on accept or MUL completion, so DONE holds them stable.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result   <= '0;
         cout     <= 1'b0;
         zero     <= 1'b0;
         set      <= 1'b0;
         overflow <= 1'b0;
         illegal  <= 1'b0;
`ifdef ALU_MC_MUL_EN
         a_r      <= '0;
         b_r      <= '0;
         cnt      <= '0;
         prod     <= '0;
`endif
      end else begin
         if (state == IDLE && in_valid) begin
            set <= slt;
`ifdef ALU_MC_MUL_EN
            if (op == OP_MUL) begin
               a_r  <= a;
               b_r  <= b;
               cnt  <= '0;
               prod <= '0;
            end else
`endif
            begin
               result   <= alu_res;
               cout     <= alu_cout;
               overflow <= alu_ovf;
               illegal  <= alu_ill;
               zero     <= (alu_res == '0);
            end
         end
`ifdef ALU_MC_MUL_EN
         if (state == MUL) begin
            prod <= prod_next;
            cnt  <= cnt + CW'(1);
            if (cnt_last) begin
               result   <= prod_next[WIDTH-1:0];
               zero     <= (prod_next[WIDTH-1:0] == '0);
               overflow <= |prod_next[2*WIDTH-1:WIDTH];
               cout     <= 1'b0;
               illegal  <= 1'b0;
            end
         end
`endif
      end
   end

endmodule

// File: tb/tb_alu_mc.sv
// Randomized scoreboard bench for alu_mc (WIDTH=32); follows ALU_MC_MUL_EN the same way the design does.
module tb_alu_mc;

   localparam int WIDTH = 32;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [WIDTH-1:0]  a = '0;
   logic [WIDTH-1:0]  b = '0;
   logic [2:0]        op = 3'b000;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [WIDTH-1:0]  result;
   logic              cout, zero, set, overflow, illegal;

   alu_mc #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .cout(cout), .zero(zero), .set(set),
      .overflow(overflow), .illegal(illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] res;
      logic        cout, zero, set, ovf, ill;
      int          lat;
      int          acc;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   stall = 0;
   logic prev_valid = 1'b0;
   logic moved_prev = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: plain signed/unsigned arithmetic on wide integers.
   function automatic exp_t model(input logic [31:0] ta, input logic [31:0] tb_, input logic [2:0] top);
      exp_t e;
      longint          sa, sb;
      longint unsigned ua, ub, p;
      sa = longint'($signed(ta));
      sb = longint'($signed(tb_));
      ua = {32'd0, ta};
      ub = {32'd0, tb_};
      e.set = (sa < sb);
      e.cout = 1'b0;
      e.ovf = 1'b0;
      e.ill = 1'b0;
      e.lat = 1;
      e.acc = 0;
      e.res = '0;
      case (top)
         3'b000: e.res = ta & tb_;
         3'b001: e.res = ta | tb_;
         3'b100: e.res = ta ^ tb_;
         3'b101: e.res = ~(ta | tb_);
         3'b010: begin
            e.res  = 32'(ua + ub);
            e.cout = (ua + ub) > 64'h0000_0000_FFFF_FFFF;
            e.ovf  = (sa + sb) != longint'($signed(e.res));
         end
         3'b110: begin
            e.res  = 32'(ua - ub);
            e.cout = (ua >= ub);
            e.ovf  = (sa - sb) != longint'($signed(e.res));
         end
         3'b111: e.res = {31'd0, e.set};
         default: begin
`ifdef ALU_MC_MUL_EN
            p     = ua * ub;
            e.res = p[31:0];
            e.ovf = (p >> 32) != 0;
            e.lat = WIDTH + 1;
`else
            p     = 0;
            e.res = '0;
            e.ill = 1'b1;
`endif
         end
      endcase
      e.zero = (e.res == 0);
      return e;
   endfunction

   task automatic issue(input logic [31:0] ta, input logic [31:0] tb_, input logic [2:0] top);
      exp_t e;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (in_ready && !rst) begin
            a = ta; b = tb_; op = top; in_valid = 1'b1;
            e = model(ta, tb_, top);
            e.acc = cyc;
            q.push_back(e);
            return;
         end
         a = $urandom; b = $urandom; op = 3'($urandom); in_valid = 1'($urandom);
      end
      chk("issue_timeout", 64'd1, 64'd0);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
   endtask

   task automatic drain();
      for (int n = 0; n < 2000 && q.size() != 0; n++) idle(1);
      chk("drain_queue_empty", 64'(q.size()), 64'd0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
      chk({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
      chk({tag, "_result"}, {32'd0, result}, 64'd0);
      chk({tag, "_flags"}, {59'd0, cout, zero, set, overflow, illegal}, 64'd0);
   endtask

   // Monitor: compares every presented output against the queue head and drives out_ready.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         prev_valid = 1'b0;
         moved_prev = 1'b0;
      end else begin
         if (moved_prev)
            chk("idle_after_transfer", {62'd0, in_ready, out_valid}, 64'd2);
         moved_prev = 1'b0;
         if (out_valid) begin
            if (q.size() == 0) begin
               chk("unexpected_out_valid", 64'd1, 64'd0);
               out_ready = 1'b1;
            end else begin
               e = q[0];
               if (!prev_valid)
                  chk("latency", 64'(cyc - e.acc), 64'(e.lat));
               chk("result", {32'd0, result}, {32'd0, e.res});
               chk("flags", {59'd0, cout, zero, set, overflow, illegal},
                   {59'd0, e.cout, e.zero, e.set, e.ovf, e.ill});
               chk("in_ready_busy", {63'd0, in_ready}, 64'd0);
               if (stall > 0) begin
                  out_ready = 1'b0;
                  stall--;
               end else begin
                  out_ready = ($urandom_range(2) != 0);
               end
               if (out_ready) begin
                  void'(q.pop_front());
                  moved_prev = 1'b1;
               end
            end
         end else begin
            out_ready = 1'($urandom);
         end
         prev_valid = out_valid;
      end
   end

   initial begin
      logic [31:0] ra, rb;
      #1 chk_reset_outputs("por");
      @(posedge clk); #2 rst = 1'b0;

      issue(32'h8000_0030, 32'hFFFF_FF38, 3'b010);
      issue(32'd5, 32'd5, 3'b110);
      issue(32'hFFFF_FFFF, 32'd1, 3'b111);
      issue(32'd3, 32'd4, 3'b011);
`ifdef ALU_MC_MUL_EN
      issue(32'h0001_0000, 32'h0001_0000, 3'b011);
      issue(32'd7, 32'd6, 3'b011);
`endif
      idle(1);
      drain();

      stall = 10;
      issue(32'h7FFF_FFFF, 32'd1, 3'b010);
      drain();

      stall = 1000;
      issue(32'h1234_5678, 32'h0000_0F0F, 3'b011);
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #2 rst = 1'b1;
      #1 chk_reset_outputs("mid_op_reset");
      q.delete();
      stall = 0;
      @(posedge clk); #2 rst = 1'b0;
      idle(6);
      issue(32'd1, 32'd2, 3'b010);
      drain();

      for (int i = 0; i < 60; i++) begin
         case ($urandom_range(3))
            0: ra = 32'h8000_0000;
            1: ra = 32'h7FFF_FFFF;
            default: ra = $urandom;
         endcase
         case ($urandom_range(3))
            0: rb = 32'd0;
            1: rb = 32'hFFFF_FFFF;
            default: rb = $urandom;
         endcase
         if (i % 7 == 0) rb = ra;
         issue(ra, rb, 3'($urandom));
      end
      idle(1);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand/result width; legal range 4..64.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset, with the ports listed below.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 in_valid  input  1  operand/op presented.
REQ-006 in_ready  output  1  block can accept; transfer when in_valid&in_ready at clk edge.
REQ-007 a, b  input  WIDTH  operands, two's complement.
REQ-008 op  input  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT, 100 XOR, 101 NOR, 011 MUL.
REQ-009 out_valid  output  1  result and flags valid.
REQ-010 out_ready  input  1  consumer accepts; transfer when out_valid&out_ready.
REQ-011 result  output  WIDTH  operation result.
REQ-012 cout, zero, set, overflow, illegal  output  1 each  status flags.

Function
REQ-013 The FSM SHALL have states IDLE, MUL, DONE; in_ready=1 only in IDLE.
REQ-014 On accept in IDLE, the block SHALL latch a, b, op; non-MUL ops go to DONE next edge, giving out_valid one cycle after acceptance.
REQ-015 MUL SHALL be unsigned shift-add, one bit of b per cycle; counter runs 0..WIDTH-1 in MUL, then DONE; out_valid first high WIDTH+1 edges after acceptance.
REQ-016 DONE SHALL hold result and all flags stable while out_ready=0; on out_ready=1 go to IDLE next edge.
REQ-017 A new input SHALL NOT be accepted in the same cycle as output transfer; max throughput one op per 2 cycles.
REQ-018 ADD: result=a+b mod 2^WIDTH; SUB: result=a+~b+1 mod 2^WIDTH.
REQ-019 cout SHALL be the carry out of bit WIDTH-1 for ADD/SUB (SUB: 1 means no borrow); 0 otherwise.
REQ-020 overflow SHALL be signed overflow for ADD/SUB; for MUL, 1 iff upper WIDTH bits of the 2*WIDTH product are nonzero; 0 otherwise.
REQ-021 set SHALL equal signed (a<b), computed as sign(a-b) XOR overflow(a-b), for every op.
REQ-022 SLT: result = zero-extended set.
REQ-023 zero SHALL be 1 iff result==0, for every op.
REQ-024 illegal SHALL be 0 for all defined ops (see REQ-030).
REQ-025 in_valid while in_ready=0 SHALL be ignored; input changes during MUL SHALL not affect the computation.

Reset
REQ-026 rst SHALL asynchronously force state IDLE, in_ready=1, out_valid=0, result=0, all flags 0, counter and product register 0.
REQ-027 rst asserted mid-MUL or in DONE SHALL discard the operation; no out_valid after release until a new accept.
REQ-028 First accept SHALL be possible on the first rising edge after rst deasserts.

Configuration
REQ-029 Macro ALU_MC_MUL_EN defined: MUL state, counter and product register SHALL be built and op 011 behaves per REQ-015/REQ-020.
REQ-030 ALU_MC_MUL_EN undefined: MUL state and its logic SHALL be absent; op 011 completes like a single-cycle op with result=0, zero=1, illegal=1, cout=overflow=0, set per REQ-021.

Verification
REQ-031 WIDTH=32, ADD a=-2147483600, b=-200 -> result=2147483496, overflow=1, cout=1, set=1, out_valid 1 cycle after accept.
REQ-032 SUB a=5, b=5 -> result=0, zero=1, cout=1, overflow=0, set=0; SLT a=-1, b=1 -> result=1, set=1.
REQ-033 MUL a=0x0001_0000, b=0x0001_0000 -> result=0, zero=1, overflow=1, out_valid exactly 33 edges after accept; MUL 7*6 -> result=42, overflow=0.
REQ-034 Hold out_ready=0 for 10 cycles in DONE -> result/flags unchanged, in_ready=0, in_valid pulses ignored; release -> IDLE next edge.
REQ-035 Assert rst at cycle 10 of a MUL -> all outputs reset immediately; after release, no out_valid until new accept; new ADD 1+2 -> result=3.
REQ-036 Build without ALU_MC_MUL_EN, op=011 a=3, b=4 -> result=0, illegal=1, out_valid 1 cycle after accept.
